// File: rtl/videox_color_pkg.sv
// Shared colour-conversion constants, pixel layout and saturation helper
// for the BT.601 RGB <-> Y'UV stream converters.
package videox_color_pkg;

  localparam int signed KY_R = 66;
  localparam int signed KY_G = 129;
  localparam int signed KY_B = 25;
  localparam int signed KU_R = -38;
  localparam int signed KU_G = -74;
  localparam int signed KU_B = 112;
  localparam int signed KV_R = 112;
  localparam int signed KV_G = -94;
  localparam int signed KV_B = -18;

  localparam int signed Y_OFF = 16;
  localparam int signed C_OFF = 128;
  localparam int signed RND   = 128;

  // a is the most significant byte, d lands in byte0 of the 32-bit pixel.
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d;
  } pix32_t;

  function automatic logic [7:0] clamp8(input int v);
    if (v < 0) begin
      return 8'd0;
    end else if (v > 255) begin
      return 8'd255;
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/nasti_stream_channel.sv
// AXI-stream style channel bundle used between video blocks.
// valid/ready: a beat transfers on a rising aclk edge where t_valid & t_ready;
// once t_valid is raised the master holds all payload fields until that edge.
interface nasti_stream_channel #(
  parameter int DATA_WIDTH = 64,
  parameter int DEST_WIDTH = 1
);
  logic                    t_valid;
  logic                    t_ready;
  logic [DATA_WIDTH-1:0]   t_data;
  logic [DATA_WIDTH/8-1:0] t_strb;
  logic [DATA_WIDTH/8-1:0] t_keep;
  logic                    t_last;
  logic [DEST_WIDTH-1:0]   t_dest;

  modport master (
    output t_valid, t_data, t_strb, t_keep, t_last, t_dest,
    input  t_ready
  );

  modport slave (
    input  t_valid, t_data, t_strb, t_keep, t_last, t_dest,
    output t_ready
  );
endinterface

// File: rtl/nasti_stream_buf.sv
// Registered stream buffer; the single-entry form accepts a new beat in the
// same cycle its stored beat leaves, so it sustains one beat per cycle.
module nasti_stream_buf #(
  parameter int BUF_SIZE   = 1,
  parameter int DATA_WIDTH = 64,
  parameter int DEST_WIDTH = 1
) (
  input logic                 aclk,
  input logic                 aresetn,
  nasti_stream_channel.slave  src,
  nasti_stream_channel.master dst
);

  generate
    if (BUF_SIZE == 1) begin : g_single
      logic                    full;
      logic                    push;
      logic [DATA_WIDTH-1:0]   data_q;
      logic [DATA_WIDTH/8-1:0] strb_q;
      logic [DATA_WIDTH/8-1:0] keep_q;
      logic                    last_q;
      logic [DEST_WIDTH-1:0]   dest_q;

      assign src.t_ready = !full || dst.t_ready;
      assign push        = src.t_valid && src.t_ready;

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          full <= 1'b0;
        end else if (push) begin
          full <= 1'b1;
        end else if (dst.t_ready) begin
          full <= 1'b0;
        end
      end

      always_ff @(posedge aclk) begin
        if (push) begin
          data_q <= src.t_data;
          strb_q <= src.t_strb;
          keep_q <= src.t_keep;
          last_q <= src.t_last;
          dest_q <= src.t_dest;
        end
      end

      assign dst.t_valid = full;
      assign dst.t_data  = data_q;
      assign dst.t_strb  = strb_q;
      assign dst.t_keep  = keep_q;
      assign dst.t_last  = last_q;
      assign dst.t_dest  = dest_q;
    end else begin : g_unsupported
      $error("nasti_stream_buf: only BUF_SIZE=1 is implemented");
    end
  endgenerate

endmodule

// File: rtl/rgb_to_yuv444.sv
// Streaming RGB888 -> packed Y'UV444 converter (BT.601 integer), two pixels
// per 64-bit beat, four-stage elastic pipeline behind a one-entry input buffer.
module rgb_to_yuv444
  import videox_color_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEST_WIDTH = 1
) (
  input logic                 aclk,
  input logic                 aresetn,
  nasti_stream_channel.slave  src,
  nasti_stream_channel.master dst
);

  localparam int NPIX = DATA_WIDTH / 32;

  nasti_stream_channel #(.DATA_WIDTH(DATA_WIDTH), .DEST_WIDTH(DEST_WIDTH)) bch ();

  nasti_stream_buf #(
    .BUF_SIZE  (1),
    .DATA_WIDTH(DATA_WIDTH),
    .DEST_WIDTH(DEST_WIDTH)
  ) u_buf (
    .aclk   (aclk),
    .aresetn(aresetn),
    .src    (src),
    .dst    (bch)
  );

  // Stage valids: to_mult (LATCH), to_add (MULT), to_clamp (SUM), out_valid (OUT).
  logic to_mult, to_add, to_clamp, out_valid;
  logic last_m, last_a, last_c, out_last;
  logic en_latch, en_mult, en_sum, en_out;

  // A stage may load when it is empty or its contents move on this cycle.
  assign en_out   = !out_valid || dst.t_ready;
  assign en_sum   = !to_clamp  || en_out;
  assign en_mult  = !to_add    || en_sum;
  assign en_latch = !to_mult   || en_mult;

  assign bch.t_ready = en_latch;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      to_mult   <= 1'b0;
      to_add    <= 1'b0;
      to_clamp  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (en_latch) to_mult   <= bch.t_valid;
      if (en_mult)  to_add    <= to_mult;
      if (en_sum)   to_clamp  <= to_add;
      if (en_out)   out_valid <= to_clamp;
      if (en_out && to_clamp) out_last <= last_c;
    end
  end

  always_ff @(posedge aclk) begin
    if (en_latch && bch.t_valid) last_m <= bch.t_last;
    if (en_mult && to_mult)      last_a <= last_m;
    if (en_sum && to_add)        last_c <= last_a;
  end

  logic [DATA_WIDTH-1:0] out_data;

  for (genvar p = 0; p < NPIX; p++) begin : g_lane
    pix32_t     in_pix;
    pix32_t     out_pix;
    int         r_q, g_q, b_q;
    int         ry, gy, by, ru, gu, bu, rv, gv, bv;
    int         y_q, u_q, v_q;
    logic [7:0] y_o, u_o, v_o;
    logic       unused_byte3;

    assign in_pix       = bch.t_data[32*p +: 32];
    assign unused_byte3 = ^in_pix.a;

    always_ff @(posedge aclk) begin
      if (en_latch && bch.t_valid) begin
        r_q <= {24'd0, in_pix.d};
        g_q <= {24'd0, in_pix.c};
        b_q <= {24'd0, in_pix.b};
      end
      if (en_mult && to_mult) begin
        ry <= KY_R * r_q;  gy <= KY_G * g_q;  by <= KY_B * b_q;
        ru <= KU_R * r_q;  gu <= KU_G * g_q;  bu <= KU_B * b_q;
        rv <= KV_R * r_q;  gv <= KV_G * g_q;  bv <= KV_B * b_q;
      end
      // Signed sums with >>> give floor division by 256 for negative chroma.
      if (en_sum && to_add) begin
        y_q <= (ry + gy + by + RND) >>> 8;
        u_q <= (ru + gu + bu + RND) >>> 8;
        v_q <= (rv + gv + bv + RND) >>> 8;
      end
      if (en_out && to_clamp) begin
        y_o <= clamp8(y_q + Y_OFF);
        u_o <= clamp8(u_q + C_OFF);
        v_o <= clamp8(v_q + C_OFF);
      end
    end

    assign out_pix = '{a: 8'h00, b: y_o, c: u_o, d: v_o};
    assign out_data[32*p +: 32] = out_pix;
  end

  logic unused_bch;
  assign unused_bch = ^{bch.t_strb, bch.t_keep, bch.t_dest};

  assign dst.t_valid = out_valid;
  assign dst.t_last  = out_last;
  assign dst.t_data  = out_data;
  assign dst.t_strb  = '1;
  assign dst.t_keep  = '1;
  assign dst.t_dest  = '0;

  // Partially strobed beats are converted anyway; flag them in simulation.
  a_full_strobe : assert property (@(posedge aclk) disable iff (!aresetn)
    src.t_valid |-> ((&src.t_keep) && (&src.t_strb)))
    else $error("rgb_to_yuv444: src beat with t_keep/t_strb not all ones");

endmodule
